// File: rtl/usb_uart_serial_port_pkg.sv
// Shared definitions for the USB CDC byte-port to 8N1 serial bridge:
// FSM state encodings and the constant functions used to size counters.
package usb_uart_serial_port_pkg;

  typedef logic [1:0] uart_state_t;

  localparam uart_state_t ST_IDLE  = 2'd0;
  localparam uart_state_t ST_START = 2'd1;
  localparam uart_state_t ST_DATA  = 2'd2;
  localparam uart_state_t ST_STOP  = 2'd3;

  // Clocks per bit. Below 4 the half-bit RX sample point collapses, so clamp.
  function automatic int calc_div(input int clk_hz, input int baud);
    int d;
    d = clk_hz / baud;
    return (d < 4) ? 4 : d;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/usb_uart_rx_fifo.sv
// Circular byte buffer between the serial receiver and the bridge write port.
// A pop frees a slot in the same cycle, so push and pop together are always accepted.
module usb_uart_rx_fifo
  import usb_uart_serial_port_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/usb_uart_serial_port.sv
// Master for the USB CDC bridge byte port: host OUT bytes are shifted out on
// ser_tx, bytes received on ser_rx are buffered and written back toward the host.
module usb_uart_serial_port
  import usb_uart_serial_port_pkg::*;
#(
  parameter int CLK_HZ        = 48000000,
  parameter int BAUD          = 115200,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic       clk_48mhz,
  input  logic       resetn,
  output logic       uart_we,
  output logic       uart_re,
  output logic [7:0] uart_di,
  input  logic [7:0] uart_do,
  input  logic       uart_wait,
  input  logic       ser_rx,
  output logic       ser_tx,
  output logic       overrun,
  output logic       frame_err,
  output logic       active
);

  localparam int DIV  = calc_div(CLK_HZ, BAUD);
  localparam int CW   = clog2(DIV) + 1;
  localparam int HALF = DIV / 2;

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

  logic        fifo_empty, fifo_full;
  logic [7:0]  fifo_head;
  logic        push, pop, rd_done;
  logic        run_q;

  logic [1:0]    tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          ser_tx_q, ser_tx_d;

  logic [1:0]    sync_q;
  logic          rx_s, rx_prev_q;
  logic [1:0]    rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          overrun_q, overrun_d;
  logic          frame_err_q, frame_err_d;

  // Writes toward the host win; a read is only offered to an idle transmitter.
  assign uart_we = ~fifo_empty;
  assign uart_re = run_q & fifo_empty & (tx_state_q == ST_IDLE);
  assign uart_di = fifo_empty ? 8'h00 : fifo_head;
  assign rd_done = uart_re & ~uart_wait;
  assign pop     = uart_we & ~uart_wait;

  assign ser_tx    = ser_tx_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
  assign active    = (tx_state_q != ST_IDLE) | (rx_state_q != ST_IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk_48mhz or negedge resetn) begin
    if (!resetn) run_q <= 1'b0;
    else         run_q <= 1'b1;
  end

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    ser_tx_d   = ser_tx_q;
    case (tx_state_q)
      ST_IDLE: begin
        tx_cnt_d = '0;
        if (rd_done) begin
          tx_state_d = ST_START;
          tx_shift_d = uart_do;
          ser_tx_d   = 1'b0;
        end
      end
      ST_START: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_state_d = ST_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
          ser_tx_d   = tx_shift_q[0];
        end
      end
      ST_DATA: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = ST_STOP;
            ser_tx_d   = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            ser_tx_d   = tx_shift_q[1];
          end
        end
      end
      default: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_state_d = ST_IDLE;
          tx_cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_48mhz or negedge resetn) begin
    if (!resetn) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      ser_tx_q   <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      ser_tx_q   <= ser_tx_d;
    end
  end

  assign rx_s = sync_q[1];

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q + 1'b1;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    push        = 1'b0;
    overrun_d   = 1'b0;
    frame_err_d = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q & ~rx_s) rx_state_d = ST_START;
      end
      ST_START: begin
        if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_d   = '0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end
      end
      default: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_state_d = ST_IDLE;
          rx_cnt_d   = '0;
          // A pop on this edge frees the slot the new byte needs.
          if (!rx_s)                 frame_err_d = 1'b1;
          else if (fifo_full && !pop) overrun_d  = 1'b1;
          else                        push       = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_48mhz or negedge resetn) begin
    if (!resetn) begin
      sync_q      <= 2'b11;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= ST_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= 3'd0;
      rx_shift_q  <= 8'h00;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], ser_rx};
      rx_prev_q   <= rx_s;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  usb_uart_rx_fifo #(
    .DEPTH (RX_FIFO_DEPTH),
    .WIDTH (8)
  ) u_rx_fifo (
    .clk_i   (clk_48mhz),
    .rst_ni  (resetn),
    .push_i  (push),
    .data_i  (rx_shift_q),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_usb_uart_serial_port.sv
// Directed bench for usb_uart_serial_port at DIV=16: TX framing, RX delivery,
// backpressure/overrun, framing error, glitch rejection and arbitration.
module tb_usb_uart_serial_port;

  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       resetn;
  logic       uart_we, uart_re, uart_wait;
  logic [7:0] uart_di, uart_do;
  logic       ser_rx, ser_tx, overrun, frame_err, active;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [7:0] wr_log [$];
  int   n_rd = 0, n_ovr = 0, n_ferr = 0, n_both = 0;
  logic we_prev = 1'b0, re_prev = 1'b0;
  logic rise_re_prev = 1'b0, rise_re_now = 1'b0;
  int   rise_cyc = 0;

  int wr_base, rd_base, ovr_base, ferr_base;
  int t_send, push_lat;

  usb_uart_serial_port #(
    .CLK_HZ        (48000000),
    .BAUD          (3000000),
    .RX_FIFO_DEPTH (4)
  ) dut (
    .clk_48mhz (clk),
    .resetn    (resetn),
    .uart_we   (uart_we),
    .uart_re   (uart_re),
    .uart_di   (uart_di),
    .uart_do   (uart_do),
    .uart_wait (uart_wait),
    .ser_rx    (ser_rx),
    .ser_tx    (ser_tx),
    .overrun   (overrun),
    .frame_err (frame_err),
    .active    (active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bridge-side observer, sampled mid-cycle.
  always @(negedge clk) begin
    if (resetn) begin
      if (uart_we && !uart_wait) wr_log.push_back(uart_di);
      if (uart_re && !uart_wait) n_rd++;
      if (overrun)               n_ovr++;
      if (frame_err)             n_ferr++;
      if (uart_we && uart_re)    n_both++;
      if (uart_we && !we_prev) begin
        rise_re_prev = re_prev;
        rise_re_now  = uart_re;
        rise_cyc     = cyc;
      end
    end
    we_prev = uart_we;
    re_prev = uart_re;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic mark();
    wr_base   = wr_log.size();
    rd_base   = n_rd;
    ovr_base  = n_ovr;
    ferr_base = n_ferr;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    @(posedge clk); #1;
    t_send = cyc;
    ser_rx = 1'b0;
    for (int b = 0; b < 8; b++) begin
      repeat (DIV) @(posedge clk);
      #1 ser_rx = d[b];
    end
    repeat (DIV) @(posedge clk);
    #1 ser_rx = stop;
    repeat (DIV) @(posedge clk);
    #1 ser_rx = 1'b1;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] fr;
    logic       got;
    int         re_busy;
    logic       ok;
    int         t0;

    ser_rx = 1'b1; uart_wait = 1'b1; uart_do = 8'h00; resetn = 1'b0;
    settle(3);
    check("rst_ser_tx",    ser_tx,    1'b1);
    check("rst_uart_we",   uart_we,   1'b0);
    check("rst_uart_re",   uart_re,   1'b0);
    check("rst_uart_di",   uart_di,   8'h00);
    check("rst_overrun",   overrun,   1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_active",    active,    1'b0);

    // Start a 0x00 frame, then reset in the middle of it.
    resetn = 1'b1; uart_wait = 1'b0;
    settle(20);
    check("midframe_tx_low", ser_tx, 1'b0);
    check("midframe_active", active, 1'b1);
    resetn = 1'b0;
    #1;
    check("midrst_ser_tx", ser_tx,  1'b1);
    check("midrst_active", active,  1'b0);
    check("midrst_re",     uart_re, 1'b0);
    uart_wait = 1'b1; uart_do = 8'hA5;
    settle(1);
    resetn = 1'b1;
    settle(4);

    // TX framing of 0xA5.
    mark();
    fr = {1'b1, 8'hA5, 1'b0};
    uart_wait = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (uart_re && !uart_wait) got = 1'b1;
    end
    check("tx_read_offered", got, 1'b1);
    check("tx_idle_before", ser_tx, 1'b1);
    @(posedge clk); #1;
    uart_wait = 1'b1;
    re_busy = 0;
    for (int k = 0; k < 10 * DIV; k++) begin
      @(negedge clk);
      if (uart_re) re_busy++;
      if ((k % DIV == 0) || (k % DIV == DIV - 1))
        check($sformatf("tx_bit%0d_c%0d", k / DIV, k % DIV), ser_tx, fr[k / DIV]);
    end
    @(negedge clk);
    check("tx_re_busy",     re_busy,        0);
    check("tx_re_after",    uart_re,        1'b1);
    check("tx_line_after",  ser_tx,         1'b1);
    check("tx_active_after", active,        1'b0);
    check("tx_read_count",  n_rd - rd_base, 1);

    // RX 0x3C into the bridge.
    @(posedge clk); #1;
    uart_wait = 1'b0;
    mark();
    send_frame(8'h3C, 1'b1);
    check("rx_write_count", wr_log.size() - wr_base, 1);
    check("rx_write_data",  wr_log[wr_base], 8'h3C);
    push_lat = rise_cyc - t_send;
    ok = (push_lat >= 9 * DIV + DIV / 2) && (push_lat <= 10 * DIV);
    check("rx_stop_sample_window", ok, 1'b1);

    // Backpressure: five bytes into a four-deep FIFO.
    uart_wait = 1'b1;
    mark();
    for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1);
    settle(4);
    check("bp_overrun_pulses", n_ovr - ovr_base, 1);
    check("bp_no_writes", wr_log.size() - wr_base, 0);
    check("bp_head", uart_di, 8'h01);
    uart_wait = 1'b0;
    settle(10);
    check("bp_write_count", wr_log.size() - wr_base, 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("bp_order%0d", i), wr_log[wr_base + i], 8'(i + 1));
    check("bp_overrun_total", n_ovr - ovr_base, 1);

    // Stop bit low, then a short glitch.
    mark();
    send_frame(8'h55, 1'b0);
    settle(4);
    check("ferr_pulses", n_ferr - ferr_base, 1);
    check("ferr_no_write", wr_log.size() - wr_base, 0);
    ser_rx = 1'b0;
    settle(4);
    ser_rx = 1'b1;
    settle(40);
    check("glitch_no_ferr",  n_ferr - ferr_base, 1);
    check("glitch_no_ovr",   n_ovr - ovr_base,   0);
    check("glitch_no_write", wr_log.size() - wr_base, 0);

    // Arbitration: stalled read withdrawn once a byte lands in the FIFO.
    uart_wait = 1'b1;
    settle(200);
    check("arb_re_pending", uart_re, 1'b1);
    mark();
    send_frame(8'h7E, 1'b1);
    settle(2);
    check("arb_re_before", rise_re_prev, 1'b1);
    check("arb_re_withdrawn", rise_re_now, 1'b0);
    check("arb_we", uart_we, 1'b1);
    check("arb_di", uart_di, 8'h7E);
    uart_wait = 1'b0;
    settle(4);
    check("arb_write_count", wr_log.size() - wr_base, 1);
    check("arb_write_data", wr_log[wr_base], 8'h7E);

    // Full FIFO: one write completes on the same edge as the stop-bit sample.
    uart_wait = 1'b1;
    mark();
    for (int b = 0; b < 4; b++) send_frame(8'h11 + 8'(b), 1'b1);
    settle(4);
    check("sim_fill_no_ovr", n_ovr - ovr_base, 0);
    fork
      send_frame(8'h15, 1'b1);
      begin
        @(posedge clk); #1;
        t0 = cyc;
        while (cyc < t0 + push_lat - 1 && cyc < t0 + 200) begin
          @(posedge clk); #1;
        end
        uart_wait = 1'b0;
        @(posedge clk); #1;
        uart_wait = 1'b1;
      end
    join
    settle(4);
    check("sim_no_overrun", n_ovr - ovr_base, 0);
    check("sim_one_write", wr_log.size() - wr_base, 1);
    check("sim_first", wr_log[wr_base], 8'h11);
    check("sim_still_pending", uart_we, 1'b1);
    uart_wait = 1'b0;
    settle(10);
    check("sim_write_count", wr_log.size() - wr_base, 5);
    for (int i = 1; i < 5; i++)
      check($sformatf("sim_order%0d", i), wr_log[wr_base + i], 8'h11 + 8'(i));

    check("never_we_and_re", n_both, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
